fwd_hazard_ctrl: RTL and testbench

FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

---
 rtl/fwd_hazard_ctrl_pkg.sv | 22 ++
 rtl/fwd_sel_prio.sv | 36 +++
 rtl/fwd_hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types for the forwarding/hazard block: shadow entry,
// select-width helper and the register-file select code.
package fwd_pkg;

   // rd is stored zero-extended to this width so that the shadow
   // entry type does not depend on the instantiating REG_AW.
   localparam int RD_MAXW = 8;

   localparam int SEL_REGFILE = 0;

   typedef struct packed {
      logic               valid;
      logic [RD_MAXW-1:0] rd;
      logic               regwrite;
      logic               is_load;
   } shadow_t;

   function automatic int sel_w(input int depth);
      return (depth < 1) ? 1 : $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fwd_sel_prio.sv
// Priority match of one source operand against all shadow entries.
// Ports: src_i/used_i operand, ent_i shadow entries (index = distance),
// hit_o per-distance match, ld_hit_o match on a load, sel_o youngest hit.
module fwd_sel_prio
   import fwd_pkg::*;
#(
   parameter int DEPTH  = 3,
   parameter int REG_AW = 5,
   parameter int SELW   = sel_w(DEPTH)
) (
   input  logic [REG_AW-1:0] src_i,
   input  logic              used_i,
   input  shadow_t [DEPTH:1] ent_i,
   output logic [DEPTH:1]    hit_o,
   output logic [DEPTH:1]    ld_hit_o,
   output logic [SELW-1:0]   sel_o
);

   always_comb begin
      hit_o    = '0;
      ld_hit_o = '0;
      sel_o    = SELW'(SEL_REGFILE);
      // Walk oldest to youngest so the youngest hit is written last.
      for (int k = DEPTH; k >= 1; k--) begin
         hit_o[k] = ent_i[k].valid & ent_i[k].regwrite
                  & (ent_i[k].rd != '0)
                  & (ent_i[k].rd == RD_MAXW'(src_i))
                  & used_i;
         ld_hit_o[k] = hit_o[k] & ent_i[k].is_load;
         if (hit_o[k]) begin
            sel_o = SELW'(k);
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select and load/branch hazard stall for an in-order pipe.
// Ports: ID operand info in, hold/flush in, stall, registered EX selects,
// combinational branch selects. FWD_HAZARD_STATS_EN adds stall_cnt/fwd_cnt.
module fwd_hazard_ctrl
   import fwd_pkg::*;
#(
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 3,
   parameter int REG_AW  = 5
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            id_valid,
   input  logic [NUM_SRC*REG_AW-1:0]       id_src,
   input  logic [NUM_SRC-1:0]              id_src_used,
   input  logic [REG_AW-1:0]               id_rd,
   input  logic                            id_regwrite,
   input  logic                            id_is_load,
   input  logic                            id_branch,
   input  logic                            hold,
   input  logic                            flush,
   output logic                            stall,
   output logic [NUM_SRC*sel_w(DEPTH)-1:0] ex_fwd_sel,
`ifdef FWD_HAZARD_STATS_EN
   output logic [15:0]                     stall_cnt,
   output logic [15:0]                     fwd_cnt,
`endif
   output logic [NUM_SRC*sel_w(DEPTH)-1:0] br_fwd_sel
);

   localparam int SELW = sel_w(DEPTH);

   shadow_t [DEPTH:1]         ent_q;
   shadow_t [DEPTH:1]         ent_d;
   logic [NUM_SRC*SELW-1:0]   ex_sel_q;
   logic [NUM_SRC*SELW-1:0]   ex_sel_d;
   logic [NUM_SRC*SELW-1:0]   id_sel;
   logic [DEPTH:1]            hit    [NUM_SRC];
   logic [DEPTH:1]            ld_hit [NUM_SRC];
   logic [NUM_SRC-1:0]        m1_v;
   logic [NUM_SRC-1:0]        ld1_v;
   logic [NUM_SRC-1:0]        ld2_v;
   logic [NUM_SRC-1:0]        unused_hit;
   logic                      stall_raw;
   logic                      issue;

   for (genvar gs = 0; gs < NUM_SRC; gs++) begin : g_src
      fwd_sel_prio #(
         .DEPTH  (DEPTH),
         .REG_AW (REG_AW),
         .SELW   (SELW)
      ) u_prio (
         .src_i    (id_src[gs*REG_AW +: REG_AW]),
         .used_i   (id_src_used[gs]),
         .ent_i    (ent_q),
         .hit_o    (hit[gs]),
         .ld_hit_o (ld_hit[gs]),
         .sel_o    (id_sel[gs*SELW +: SELW])
      );
      assign m1_v[gs]       = hit[gs][1];
      assign ld1_v[gs]      = ld_hit[gs][1];
      assign unused_hit[gs] = ^{hit[gs], ld_hit[gs]};
      if (DEPTH >= 2) begin : g_d2
         assign ld2_v[gs] = ld_hit[gs][2];
      end else begin : g_nod2
         assign ld2_v[gs] = 1'b0;
      end
   end

   // A branch resolves in ID, so it cannot take any distance-1 result,
   // nor a load result that is still one stage from writeback.
   always_comb begin
      stall_raw = 1'b0;
      if (id_branch) begin
         stall_raw = (|m1_v) | (|ld2_v);
      end else begin
         stall_raw = |ld1_v;
      end
   end

   assign stall      = id_valid & ~flush & stall_raw;
   assign issue      = id_valid & ~flush & ~stall_raw;
   assign br_fwd_sel = id_sel;
   assign ex_fwd_sel = ex_sel_q;

   always_comb begin
      ent_d    = ent_q;
      ex_sel_d = ex_sel_q;
      if (!hold) begin
         for (int k = DEPTH; k >= 2; k--) begin
            ent_d[k] = ent_q[k-1];
         end
         ent_d[1] = '0;
         if (issue) begin
            ent_d[1].valid    = 1'b1;
            ent_d[1].rd       = RD_MAXW'(id_rd);
            ent_d[1].regwrite = id_regwrite;
            ent_d[1].is_load  = id_is_load;
         end
         ex_sel_d = issue ? id_sel : '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ent_q    <= '0;
         ex_sel_q <= '0;
      end else begin
         ent_q    <= ent_d;
         ex_sel_q <= ex_sel_d;
      end
   end

`ifdef FWD_HAZARD_STATS_EN
   logic [15:0] stall_cnt_q;
   logic [15:0] stall_cnt_d;
   logic [15:0] fwd_cnt_q;
   logic [15:0] fwd_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      fwd_cnt_d   = fwd_cnt_q;
      if (stall && !hold && stall_cnt_q != 16'hFFFF) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
      if (issue && !hold && (|id_sel) && fwd_cnt_q != 16'hFFFF) begin
         fwd_cnt_d = fwd_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q <= '0;
         fwd_cnt_q   <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         fwd_cnt_q   <= fwd_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed scenarios plus random traffic
// against a distance-history reference model.
module tb_fwd_hazard_ctrl;

   localparam int NS = 2;
   localparam int D  = 3;
   localparam int AW = 5;
   localparam int SW = 2;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             id_valid;
   logic [NS*AW-1:0] id_src;
   logic [NS-1:0]    id_src_used;
   logic [AW-1:0]    id_rd;
   logic             id_regwrite;
   logic             id_is_load;
   logic             id_branch;
   logic             hold;
   logic             flush;
   logic             stall;
   logic [NS*SW-1:0] ex_fwd_sel;
   logic [NS*SW-1:0] br_fwd_sel;
`ifdef FWD_HAZARD_STATS_EN
   logic [15:0]      stall_cnt;
   logic [15:0]      fwd_cnt;
   int               m_scnt = 0;
   int               m_fcnt = 0;
`endif

   fwd_hazard_ctrl #(.NUM_SRC(NS), .DEPTH(D), .REG_AW(AW)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .id_valid    (id_valid),
      .id_src      (id_src),
      .id_src_used (id_src_used),
      .id_rd       (id_rd),
      .id_regwrite (id_regwrite),
      .id_is_load  (id_is_load),
      .id_branch   (id_branch),
      .hold        (hold),
      .flush       (flush),
      .stall       (stall),
      .ex_fwd_sel  (ex_fwd_sel),
`ifdef FWD_HAZARD_STATS_EN
      .stall_cnt   (stall_cnt),
      .fwd_cnt     (fwd_cnt),
`endif
      .br_fwd_sel  (br_fwd_sel)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int last_stall;

   // Reference: producers by distance from ID, plus expected EX selects.
   bit hv  [1:D];
   int hrd [1:D];
   bit hrw [1:D];
   bit hld [1:D];
   int mex [NS];

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit mt(input int s, input int d);
      int src;
      src = int'(id_src[s*AW +: AW]);
      return hv[d] && hrw[d] && hrd[d] != 0 && hrd[d] == src
             && id_src_used[s];
   endfunction

   task automatic mreset();
      for (int d = 1; d <= D; d++) begin
         hv[d] = 0; hrd[d] = 0; hrw[d] = 0; hld[d] = 0;
      end
      for (int s = 0; s < NS; s++) mex[s] = 0;
   endtask

   function automatic int esel(input int s);
      for (int d = 1; d <= D; d++) if (mt(s, d)) return d;
      return 0;
   endfunction

   // Inputs already applied at the negedge; compare, then advance model.
   task automatic step();
      bit e_stall;
      bit haz;
      bit iss;
      bit anysel;
      int sel [NS];
      #1;
      haz = 0;
      anysel = 0;
      for (int s = 0; s < NS; s++) begin
         sel[s] = esel(s);
         if (sel[s] != 0) anysel = 1;
         if (id_branch) begin
            if (mt(s, 1) || (mt(s, 2) && hld[2])) haz = 1;
         end else begin
            if (mt(s, 1) && hld[1]) haz = 1;
         end
      end
      e_stall = id_valid && !flush && haz;
      chk("stall", int'(stall), int'(e_stall));
      for (int s = 0; s < NS; s++) begin
         chk("br_sel", int'(br_fwd_sel[s*SW +: SW]), sel[s]);
         chk("ex_sel", int'(ex_fwd_sel[s*SW +: SW]), mex[s]);
      end
`ifdef FWD_HAZARD_STATS_EN
      chk("stall_cnt", int'(stall_cnt), m_scnt);
      chk("fwd_cnt", int'(fwd_cnt), m_fcnt);
`endif
      last_stall = int'(stall);
      if (!hold) begin
         iss = id_valid && !flush && !e_stall;
`ifdef FWD_HAZARD_STATS_EN
         if (e_stall && m_scnt < 65535) m_scnt++;
         if (iss && anysel && m_fcnt < 65535) m_fcnt++;
`endif
         for (int d = D; d >= 2; d--) begin
            hv[d] = hv[d-1]; hrd[d] = hrd[d-1];
            hrw[d] = hrw[d-1]; hld[d] = hld[d-1];
         end
         hv[1]  = iss;
         hrd[1] = iss ? int'(id_rd) : 0;
         hrw[1] = iss && id_regwrite;
         hld[1] = iss && id_is_load;
         for (int s = 0; s < NS; s++) mex[s] = iss ? sel[s] : 0;
      end
   endtask

   task automatic put(input bit v, input int s0, input bit u0,
                      input int s1, input bit u1, input int rd,
                      input bit rw, input bit ld, input bit br,
                      input bit hd, input bit fl);
      @(negedge clk);
      id_valid    = v;
      id_src      = {AW'(s1), AW'(s0)};
      id_src_used = {u1, u0};
      id_rd       = AW'(rd);
      id_regwrite = rw;
      id_is_load  = ld;
      id_branch   = br;
      hold        = hd;
      flush       = fl;
      step();
   endtask

   task automatic idle(input int n);
      repeat (n) put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      id_valid = 0; id_src = '0; id_src_used = '0; id_rd = '0;
      id_regwrite = 0; id_is_load = 0; id_branch = 0;
      hold = 0; flush = 0;
      mreset();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_stall", int'(stall), 0);
      chk("rst_ex", int'(ex_fwd_sel), 0);
      chk("rst_br", int'(br_fwd_sel), 0);
      reset_n = 1'b1;

      // ALU producer r3, consumer next cycle
      put(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
      put(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("alu_nostall", last_stall, 0);
      idle(1);
      chk("alu_ex_sel", int'(ex_fwd_sel[SW-1:0]), 1);

      // load-use on r4
      idle(3);
      put(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0);
      put(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("ldu_stall", last_stall, 1);
      put(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("ldu_release", last_stall, 0);
      idle(1);
      chk("ldu_ex_sel", int'(ex_fwd_sel[SW-1:0]), 2);

      // load r5 feeding a branch
      idle(3);
      put(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
      put(1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      chk("ldbr_st1", last_stall, 1);
      put(1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      chk("ldbr_st2", last_stall, 1);
      put(1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      chk("ldbr_rel", last_stall, 0);
      chk("ldbr_br_sel", int'(br_fwd_sel[SW-1:0]), 3);

      // r0 never forwards; youngest of two r7 writers wins
      idle(3);
      put(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
      put(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      put(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
      put(1, 0, 1, 7, 1, 0, 0, 0, 0, 0, 0);
      chk("r0_sel", int'(br_fwd_sel[SW-1:0]), 0);
      chk("r7_sel", int'(br_fwd_sel[2*SW-1:SW]), 1);

      // flush beats stall; flushed load must not enter the shadow pipe
      idle(3);
      put(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0);
      put(1, 4, 1, 0, 0, 4, 1, 1, 0, 0, 1);
      chk("flush_stall", last_stall, 0);
      put(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("flush_nostall", last_stall, 0);
      chk("flush_sel", int'(br_fwd_sel[SW-1:0]), 2);

      // hold for 5 cycles in the middle of a load-use stall
      idle(3);
      put(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0);
      repeat (5) put(1, 6, 1, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("hold_stall", last_stall, 1);
      put(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("hold_resume", last_stall, 1);
      put(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("hold_release", last_stall, 0);
      idle(1);
      chk("hold_ex_sel", int'(ex_fwd_sel[SW-1:0]), 2);

      // reset during a load-to-branch stall
      idle(3);
      put(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
      put(1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      chk("rstmid_pre", last_stall, 1);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("rstmid_stall", int'(stall), 0);
      chk("rstmid_br", int'(br_fwd_sel), 0);
      chk("rstmid_ex", int'(ex_fwd_sel), 0);
      mreset();
`ifdef FWD_HAZARD_STATS_EN
      m_scnt = 0;
      m_fcnt = 0;
`endif
      #2;
      reset_n = 1'b1;
      put(1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      chk("post_rst_stall", last_stall, 0);
      chk("post_rst_br", int'(br_fwd_sel), 0);

      // random traffic on a small register set to provoke hazards
      for (int i = 0; i < 800; i++) begin
         put($urandom_range(3, 0) != 0,
             $urandom_range(3, 0), 1'($urandom),
             $urandom_range(3, 0), 1'($urandom),
             $urandom_range(3, 0), 1'($urandom), 1'($urandom),
             $urandom_range(3, 0) == 0,
             $urandom_range(7, 0) == 0,
             $urandom_range(7, 0) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
